// File: rtl/calc_ctrl.sv
// calc_ctrl: two-operand decimal calculator controller.
// Keys arrive as a 4-bit code plus a toggle strobe. Two operands (0-99) are
// entered digit by digit. An add/subtract/multiply result is converted to BCD
// with a sequential double-dabble, one bit per cycle.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   char   in   [3:0] key code: 0-9 digit, 10 add, 11 sub, 12 mul, 13 enter
//   flag   in   toggles once per key; each toggle is one key event
//   disp   out  [15:0] four BCD digits {thousands, hundreds, tens, ones}
//   neg    out  result-is-negative (meaningful only in S_RES)
//   state  out  [1:0] current state code
//   busy   out  high while the BCD conversion runs
//
// state  | meaning
// S_A    | entering operand A, display shows A
// S_B    | entering operand B, display shows B
// S_CONV | 14-cycle double-dabble conversion, keys held pending
// S_RES  | result shown; a digit starts a new calculation
module calc_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  char,
    input  logic        flag,
    output logic [15:0] disp,
    output logic        neg,
    output logic [1:0]  state,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_CONV = 2'd2,
        S_RES  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2
    } op_t;

    localparam logic [3:0] CONV_LAST = 4'd13;

    state_t      state_q, state_d;
    op_t         op_q, op_d;
    logic [6:0]  a_q, a_d;
    logic [6:0]  b_q, b_d;
    logic        flag_q, flag_d;
    logic        neg_q, neg_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [29:0] sh_q, sh_d;
    logic [15:0] disp_q, disp_d;

    logic        key_evt;
    logic        is_digit;
    logic        is_op;
    logic        is_enter;
    logic [6:0]  a_shift;
    logic [6:0]  b_shift;
    logic [13:0] res;
    logic        res_neg;
    logic [29:0] sh_step;
    op_t         op_key;

    // Keep only the last two typed digits.
    function automatic logic [6:0] shift_digit(input logic [6:0] x, input logic [3:0] d);
        return 7'((x % 7'd10) * 7'd10 + {3'b000, d});
    endfunction

    function automatic logic [7:0] bcd2(input logic [6:0] x);
        return {4'(x / 7'd10), 4'(x % 7'd10)};
    endfunction

    // One double-dabble iteration: BCD field sits in [29:14], binary in [13:0].
    function automatic logic [29:0] dabble_step(input logic [29:0] s);
        logic [29:0] t;
        t = s;
        for (int i = 0; i < 4; i++) begin
            if (t[14 + 4*i +: 4] >= 4'd5) begin
                t[14 + 4*i +: 4] = t[14 + 4*i +: 4] + 4'd3;
            end
        end
        return {t[28:0], 1'b0};
    endfunction

    assign key_evt  = (flag != flag_q);
    assign is_digit = (char <= 4'd9);
    assign is_op    = (char >= 4'd10) && (char <= 4'd12);
    assign is_enter = (char == 4'd13);
    assign a_shift  = shift_digit(a_q, char);
    assign b_shift  = shift_digit(b_q, char);
    assign sh_step  = dabble_step(sh_q);

    always_comb begin
        op_key = OP_ADD;
        case (char)
            4'd11:   op_key = OP_SUB;
            4'd12:   op_key = OP_MUL;
            default: op_key = OP_ADD;
        endcase
    end

    always_comb begin
        res     = 14'd0;
        res_neg = 1'b0;
        case (op_q)
            OP_SUB: begin
                if (a_q < b_q) begin
                    res     = 14'(b_q - a_q);
                    res_neg = 1'b1;
                end else begin
                    res = 14'(a_q - b_q);
                end
            end
            OP_MUL:  res = 14'(a_q) * 14'(b_q);
            default: res = 14'(a_q) + 14'(b_q);
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        neg_d   = neg_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        disp_d  = disp_q;
        // The strobe is frozen during conversion so a key stays pending.
        flag_d  = (state_q == S_CONV) ? flag_q : flag;

        case (state_q)
            S_A: begin
                if (key_evt) begin
                    if (is_digit) begin
                        a_d    = a_shift;
                        disp_d = {8'h00, bcd2(a_shift)};
                    end else if (is_op) begin
                        op_d    = op_key;
                        b_d     = 7'd0;
                        state_d = S_B;
                        disp_d  = 16'h0000;
                    end
                end
            end
            S_B: begin
                if (key_evt) begin
                    if (is_digit) begin
                        b_d    = b_shift;
                        disp_d = {8'h00, bcd2(b_shift)};
                    end else if (is_op) begin
                        op_d = op_key;
                    end else if (is_enter) begin
                        neg_d   = res_neg;
                        sh_d    = {16'h0000, res};
                        cnt_d   = CONV_LAST;
                        state_d = S_CONV;
                    end
                end
            end
            S_CONV: begin
                sh_d = sh_step;
                if (cnt_q == 4'd0) begin
                    disp_d  = sh_step[29:14];
                    state_d = S_RES;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RES: begin
                if (key_evt && is_digit) begin
                    a_d     = {3'b000, char};
                    b_d     = 7'd0;
                    neg_d   = 1'b0;
                    state_d = S_A;
                    disp_d  = {12'h000, char};
                end
            end
            default: state_d = S_A;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_A;
            op_q    <= OP_ADD;
            a_q     <= 7'd0;
            b_q     <= 7'd0;
            flag_q  <= 1'b0;
            neg_q   <= 1'b0;
            cnt_q   <= 4'd0;
            sh_q    <= 30'd0;
            disp_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            flag_q  <= flag_d;
            neg_q   <= neg_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            disp_q  <= disp_d;
        end
    end

    assign disp  = disp_q;
    assign neg   = (state_q == S_RES) && neg_q;
    assign state = state_q;
    assign busy  = (state_q == S_CONV);

endmodule
